// File: rtl/rect_motion_if.sv
`default_nettype none
// ============================================================================
// rect_motion_if : configuration handshake between a host and rect_motion_ctrl
// Revision: 1.0
// ============================================================================
interface rect_motion_if #(
  parameter int CORDW = 10,
  parameter int SPDW  = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CORDW-1:0] cfg_w;
  logic [CORDW-1:0] cfg_h;
  logic [SPDW-1:0]  cfg_dx;
  logic [SPDW-1:0]  cfg_dy;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_w, cfg_h, cfg_dx, cfg_dy,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_w, cfg_h, cfg_dx, cfg_dy,
    output cfg_ready, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/rect_motion_ctrl.sv
`default_nettype none
// ============================================================================
// rect_motion_ctrl : frame-synchronous bounce and config owner of the rectangle
// Revision: 1.0
// ============================================================================
module rect_motion_ctrl #(
  parameter int CORDW   = 10,
  parameter int SPDW    = 8,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int INIT_X  = 220,
  parameter int INIT_Y  = 40,
  parameter int INIT_W  = 200,
  parameter int INIT_H  = 400,
  parameter int INIT_DX = 1,
  parameter int INIT_DY = 1
) (
  input  wire logic             clk_pix,
  input  wire logic             rst_pix,
  input  wire logic [CORDW-1:0] sx,
  input  wire logic [CORDW-1:0] sy,
  rect_motion_if.slave          cfg,
  output logic      [CORDW-1:0] rect_x,
  output logic      [CORDW-1:0] rect_y,
  output logic      [CORDW-1:0] rect_w,
  output logic      [CORDW-1:0] rect_h,
  output logic                  draw
);
  localparam int AW = CORDW + 2;

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_MOVE_X = 2'd1;
  localparam logic [1:0] ST_MOVE_Y = 2'd2;
  localparam logic [1:0] ST_CFG    = 2'd3;

  localparam logic [AW-1:0]    HRES_E = AW'(H_RES);
  localparam logic [AW-1:0]    VRES_E = AW'(V_RES);
  localparam logic [CORDW-1:0] TRIG_Y = CORDW'(V_RES);

  logic [1:0]       state_q, state_d;
  logic [CORDW-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [SPDW-1:0]  dx_q, dx_d, dy_q, dy_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = moving toward 0
  logic             pend_q, pend_d;
  logic [CORDW-1:0] pw_q, pw_d, ph_q, ph_d;
  logic [SPDW-1:0]  pdx_q, pdx_d, pdy_q, pdy_d;
  logic             err_q, err_d;
  logic             draw_q, draw_d;

  logic [CORDW:0]   w_bx, w_by;
  logic [AW-1:0]    w_room_x, w_room_y;
  logic             w_cfg_ok;

  // Returns {new_dir, new_pos}; edges clamp exactly onto the boundary and flip.
  function automatic logic [CORDW:0] bounce(
    input logic [CORDW-1:0] pos,
    input logic [CORDW-1:0] len,
    input logic [SPDW-1:0]  spd,
    input logic [AW-1:0]    lim,
    input logic             neg
  );
    logic [AW-1:0]  p, l, s;
    logic [CORDW:0] r;
    p = AW'(pos);
    l = AW'(len);
    s = AW'(spd);
    r = {neg, pos};
    if (s != '0) begin
      if (!neg) begin
        if (p + s + l >= lim) r = {1'b1, CORDW'(lim - l)};
        else                  r = {1'b0, CORDW'(p + s)};
      end else if (s >= p) begin
        r = {1'b0, {CORDW{1'b0}}};
      end else begin
        r = {1'b1, CORDW'(p - s)};
      end
    end
    return r;
  endfunction

  assign w_bx     = bounce(x_q, w_q, dx_q, HRES_E, dir_x_q);
  assign w_by     = bounce(y_q, h_q, dy_q, VRES_E, dir_y_q);
  assign w_room_x = HRES_E - AW'(pw_q);
  assign w_room_y = VRES_E - AW'(ph_q);
  assign w_cfg_ok = (pw_q != '0) && (AW'(pw_q) <= HRES_E) &&
                    (ph_q != '0) && (AW'(ph_q) <= VRES_E);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q <= ST_ACTIVE;
      x_q     <= CORDW'(INIT_X);
      y_q     <= CORDW'(INIT_Y);
      w_q     <= CORDW'(INIT_W);
      h_q     <= CORDW'(INIT_H);
      dx_q    <= SPDW'(INIT_DX);
      dy_q    <= SPDW'(INIT_DY);
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      pend_q  <= 1'b0;
      pw_q    <= '0;
      ph_q    <= '0;
      pdx_q   <= '0;
      pdy_q   <= '0;
      err_q   <= 1'b0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      pend_q  <= pend_d;
      pw_q    <= pw_d;
      ph_q    <= ph_d;
      pdx_q   <= pdx_d;
      pdy_q   <= pdy_d;
      err_q   <= err_d;
      draw_q  <= draw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE: if (sx == '0 && sy == TRIG_Y) state_d = ST_MOVE_X;
      ST_MOVE_X: state_d = ST_MOVE_Y;
      ST_MOVE_Y: state_d = ST_CFG;
      default:   state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    pend_d  = pend_q;
    pw_d    = pw_q;
    ph_d    = ph_q;
    pdx_d   = pdx_q;
    pdy_d   = pdy_q;
    err_d   = 1'b0;

    if (cfg.cfg_valid && !pend_q) begin
      pend_d = 1'b1;
      pw_d   = cfg.cfg_w;
      ph_d   = cfg.cfg_h;
      pdx_d  = cfg.cfg_dx;
      pdy_d  = cfg.cfg_dy;
    end

    case (state_q)
      ST_MOVE_X: {dir_x_d, x_d} = w_bx;
      ST_MOVE_Y: {dir_y_d, y_d} = w_by;
      ST_CFG: begin
        // A full slot is never accepted into in the same cycle, so clearing wins.
        if (pend_q) begin
          pend_d = 1'b0;
          if (w_cfg_ok) begin
            w_d  = pw_q;
            h_d  = ph_q;
            dx_d = pdx_q;
            dy_d = pdy_q;
            if (AW'(x_q) > w_room_x) x_d = w_room_x[CORDW-1:0];
            if (AW'(y_q) > w_room_y) y_d = w_room_y[CORDW-1:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    draw_d = (AW'(sx) >= AW'(x_q)) && (AW'(sx) < AW'(x_q) + AW'(w_q)) &&
             (AW'(sy) >= AW'(y_q)) && (AW'(sy) < AW'(y_q) + AW'(h_q));
  end

  always_comb begin
    cfg.cfg_ready = !pend_q;
    cfg.cfg_err   = err_q;
    rect_x        = x_q;
    rect_y        = y_q;
    rect_w        = w_q;
    rect_h        = h_q;
    draw          = draw_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_rect_motion_ctrl.sv
`default_nettype none
// Bench for rect_motion_ctrl: directed scenarios plus random frames checked
// against a frame-level model of the rectangle and the config slot.
module tb_rect_motion_ctrl;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sx  = '0;
  logic [9:0] sy  = '0;
  logic [9:0] rect_x, rect_y, rect_w, rect_h;
  logic       draw;

  rect_motion_if #(.CORDW(10), .SPDW(8)) cif ();

  rect_motion_ctrl dut (
    .clk_pix (clk),
    .rst_pix (rst),
    .sx      (sx),
    .sy      (sy),
    .cfg     (cif),
    .rect_x  (rect_x),
    .rect_y  (rect_y),
    .rect_w  (rect_w),
    .rect_h  (rect_h),
    .draw    (draw)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_x, m_y, m_w, m_h, m_dx, m_dy;
  bit m_nx, m_ny, m_pend, m_err, m_draw;
  int p_w, p_h, p_dx, p_dy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_rect(input int px, input int py);
    return px >= m_x && px < m_x + m_w && py >= m_y && py < m_y + m_h;
  endfunction

  task automatic model_reset();
    m_x = 220; m_y = 40; m_w = 200; m_h = 400; m_dx = 1; m_dy = 1;
    m_nx = 0; m_ny = 0; m_pend = 0; m_err = 0; m_draw = 0;
  endtask

  task automatic move(inout int p, inout bit neg, input int len, input int spd, input int lim);
    if (spd == 0) return;
    if (!neg) begin
      if (p + spd + len >= lim) begin p = lim - len; neg = 1; end
      else p = p + spd;
    end else begin
      if (spd >= p) begin p = 0; neg = 0; end
      else p = p - spd;
    end
  endtask

  // phase: 0 idle, 1 x-move edge, 2 y-move edge, 3 config-apply edge
  task automatic step(input int phase);
    bit pre, fire, ed;
    int cw, ch, cdx, cdy;
    pre  = m_pend;
    fire = cif.cfg_valid && !pre;
    ed   = in_rect(int'(sx), int'(sy));
    cw = int'(cif.cfg_w); ch = int'(cif.cfg_h); cdx = int'(cif.cfg_dx); cdy = int'(cif.cfg_dy);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_err = 0;
      if (phase == 1) move(m_x, m_nx, m_w, m_dx, H_RES);
      if (phase == 2) move(m_y, m_ny, m_h, m_dy, V_RES);
      if (phase == 3 && pre) begin
        m_pend = 0;
        if (p_w >= 1 && p_w <= H_RES && p_h >= 1 && p_h <= V_RES) begin
          m_w = p_w; m_h = p_h; m_dx = p_dx; m_dy = p_dy;
          if (m_x > H_RES - m_w) m_x = H_RES - m_w;
          if (m_y > V_RES - m_h) m_y = V_RES - m_h;
        end else begin
          m_err = 1;
        end
      end
      if (fire) begin
        m_pend = 1; p_w = cw; p_h = ch; p_dx = cdx; p_dy = cdy;
      end
      m_draw = ed;
    end
    chk("cfg_ready", cif.cfg_ready, !m_pend);
    chk("cfg_err", cif.cfg_err, m_err);
    chk("rect_x", rect_x, m_x);
    chk("rect_y", rect_y, m_y);
    chk("rect_w", rect_w, m_w);
    chk("rect_h", rect_h, m_h);
    chk("draw", draw, m_draw);
  endtask

  task automatic do_reset();
    rst = 1; step(0); rst = 0;
  endtask

  // Ends in cycle T+4, right after the config-apply edge.
  task automatic trig();
    sx = 0; sy = 10'(V_RES); step(0);
    sx = 1; step(1); step(2); step(3);
  endtask

  task automatic frame();
    trig(); step(0);
  endtask

  task automatic idle();
    sx = 10'($urandom_range(799, 0));
    sy = 10'($urandom_range(524, 0));
    if (sx == 0 && sy == 10'(V_RES)) sx = 1;
    step(0);
  endtask

  task automatic offer(input int w, input int h, input int dx, input int dy);
    cif.cfg_w = 10'(w); cif.cfg_h = 10'(h); cif.cfg_dx = 8'(dx); cif.cfg_dy = 8'(dy);
    cif.cfg_valid = 1;
  endtask

  initial begin
    cif.cfg_valid = 0; cif.cfg_w = '0; cif.cfg_h = '0; cif.cfg_dx = '0; cif.cfg_dy = '0;
    model_reset();
    do_reset();
    chk("rst_x", rect_x, 220);
    chk("rst_w", rect_w, 200);
    chk("rst_draw", draw, 0);

    // Draw boundaries at reset geometry
    sx = 220; sy = 40;  step(0); chk("draw_tl", draw, 1);
    sx = 419; sy = 40;  step(0); chk("draw_right_in", draw, 1);
    sx = 420; sy = 40;  step(0); chk("draw_right_out", draw, 0);
    sx = 300; sy = 440; step(0); chk("draw_bottom_out", draw, 0);

    // Three plain frames
    repeat (3) frame();
    chk("f3_x", rect_x, 223);
    chk("f3_y", rect_y, 43);
    chk("f3_w", rect_w, 200);
    chk("f3_h", rect_h, 400);

    // Wide config with clamping and bouncing
    do_reset();
    offer(600, 400, 30, 0); step(0); cif.cfg_valid = 0;
    frame(); chk("wide_t1_x", rect_x, 40); chk("wide_t1_y", rect_y, 41);
    frame(); chk("wide_t2_x", rect_x, 40);
    frame(); chk("wide_t3_x", rect_x, 10);
    frame(); chk("wide_t4_x", rect_x, 0); chk("wide_t4_y", rect_y, 41);
    frame();

    // Invalid config
    do_reset();
    offer(0, 100, 1, 1); step(0); cif.cfg_valid = 0;
    chk("inv_ready_held", cif.cfg_ready, 0);
    trig();
    chk("inv_err_t4", cif.cfg_err, 1);
    chk("inv_ready_t4", cif.cfg_ready, 1);
    step(0);
    chk("inv_err_t5", cif.cfg_err, 0);
    chk("inv_w", rect_w, 200);

    // Two back-to-back configs with valid held
    do_reset();
    offer(300, 200, 2, 3); step(0);
    chk("two_ready_a1", cif.cfg_ready, 0);
    offer(100, 100, 5, 5); step(0); step(0);
    trig();
    chk("two_first_w", rect_w, 300);
    chk("two_ready_t4", cif.cfg_ready, 1);
    step(0);
    chk("two_ready_t5", cif.cfg_ready, 0);
    chk("two_still_w", rect_w, 300);
    cif.cfg_valid = 0;
    frame();
    chk("two_second_w", rect_w, 100);

    // Reset in the middle of the update sequence drops the pending config
    do_reset();
    offer(100, 100, 4, 4); step(0); cif.cfg_valid = 0;
    sx = 0; sy = 10'(V_RES); step(0);
    sx = 1; step(1);
    rst = 1; step(0); rst = 0;
    chk("mid_rst_x", rect_x, 220);
    chk("mid_rst_ready", cif.cfg_ready, 1);
    frame();
    chk("mid_rst_w", rect_w, 200);
    chk("mid_rst_x2", rect_x, 221);

    // Random frames with random configs and random pixel probes
    repeat (40) begin
      if ($urandom_range(2, 0) != 0) begin
        offer($urandom_range(700, 0), $urandom_range(520, 0),
              $urandom_range(60, 0), $urandom_range(60, 0));
        repeat ($urandom_range(3, 1)) idle();
        cif.cfg_valid = 0;
      end
      repeat ($urandom_range(8, 2)) idle();
      if ($urandom_range(9, 0) == 0) offer($urandom_range(640, 1), $urandom_range(480, 1), 7, 9);
      frame();
      cif.cfg_valid = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rect_motion_ctrl.md
# rect_motion_ctrl

Frame-synchronous controller that owns the rectangle geometry used by the paint stage in the simple_480p graphics pipeline. Once per frame, at the start of vertical blanking, it sequences a bounce update of position, then applies at most one buffered geometry/speed configuration received over a valid/ready port. It also produces a registered per-pixel `draw` flag for the paint stage. Geometry outputs change only during blanking, so a frame never tears.

## Interface
- CORDW, 10: coordinate width.
- SPDW, 8: speed width.
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines per frame.
- INIT_X, 220 / INIT_Y, 40: reset position, top-left.
- INIT_W, 200 / INIT_H, 400: reset size.
- INIT_DX, 1 / INIT_DY, 1: reset speed, pixels per frame.
- clk_pix  in  1  pixel clock
- rst_pix  in  1  reset; one clock, synchronous, active-high
- sx, sy  in  CORDW each  current screen position from simple_480p
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration slot free
- cfg_w, cfg_h  in  CORDW each  requested size
- cfg_dx, cfg_dy  in  SPDW each  requested speed magnitudes
- cfg_err  out  1  one-cycle pulse: invalid config discarded
- rect_x, rect_y, rect_w, rect_h  out  CORDW each  current geometry
- draw  out  1  registered "pixel inside rect"

## Operation
- Reset: state ACTIVE; rect_x/y/w/h = INIT_X/Y/W/H; dx/dy = INIT_DX/DY; dir_x = dir_y = +; pending slot empty; cfg_err = 0; draw = 0.
- While rst_pix is high, all inputs are ignored. Reset mid-frame or mid-sequence discards any pending config.
- Trigger: in ACTIVE, `sx == 0 && sy == V_RES` sampled at a clock edge.
- FSM: ACTIVE -> MOVE_X -> MOVE_Y -> CFG -> ACTIVE. Each state after ACTIVE lasts one cycle; the sequence is unconditional.
- MOVE_X, positive direction:
  - If x+dx+w >= H_RES: x = H_RES-w and dir_x flips.
  - Otherwise: x += dx.
- MOVE_X, negative direction:
  - If dx >= x: x = 0 and dir_x flips.
  - Otherwise: x -= dx.
- If dx == 0, x and dir_x are held.
- MOVE_Y: same rules using y, h, dy, dir_y, V_RES.
- Arithmetic: all sums and compares use CORDW+2 bits, with no wrap.
- cfg_ready = !pending, combinational.
  - A config is accepted on any edge where cfg_valid && cfg_ready, and is latched into the pending slot.
  - Accepted values are not visible in outputs until the next CFG state.
- CFG, slot full and config valid (1 <= w <= H_RES, 1 <= h <= V_RES):
  - w, h, dx, dy are replaced; directions are kept.
  - x = min(x, H_RES-w) and y = min(y, V_RES-h).
  - The slot is cleared.
- CFG, slot full and config invalid: geometry is unchanged, cfg_err pulses during CFG, and the slot is cleared.
- CFG, slot empty: no change.
- A config accepted in the CFG cycle itself (slot was empty) is held and applied at the next frame's CFG.
- Draw: `draw <= (sx >= x) && (sx < x+w) && (sy >= y) && (sy < y+h)`, using current outputs. Independent of de.

## Timing
- Trigger edge T. State is MOVE_X during cycle T+1.
- New rect_x is visible from T+2, new rect_y from T+3, config result from T+4. The FSM is back in ACTIVE at T+4.
- cfg_err is high for exactly the cycle after the CFG edge (T+4).
- Cycle of acceptance edge A: cfg_ready = 0 from A+1 until the slot clears, and reads 1 again from T+4.
- draw latency is one clock from sx/sy.
- All updates complete deep inside vertical blanking, so outputs are stable for every active pixel.

## Test plan
- Reset, then 3 triggers -> rect_x = 223, rect_y = 43, rect_w = 200, rect_h = 400, cfg_err never asserted.
- From reset, offer cfg w = 600, h = 400, dx = 30, dy = 0 before the first trigger. Required rect_x after each trigger:
  - Trigger 1: x moves to 221, then clamps to 40; y = 41.
  - Trigger 2: x = 40, dir flips to negative.
  - Trigger 3: x = 10.
  - Trigger 4: x = 0, dir flips to positive.
  - y stays 41 throughout.
- Offer cfg w = 0 -> accepted; at the next trigger cfg_err pulses at T+4 for one cycle, rect_w stays 200, cfg_ready returns to 1 at T+4.
- Hold cfg_valid for two different configs -> first accepted at edge A, cfg_ready = 0 from A+1 until T+4, second accepted at T+4 and applied only at the following trigger.
- Geometry 220/40/200/400, drive sx/sy:
  - (220,40) -> draw = 1 one clock later.
  - (419,40) -> draw = 1.
  - (420,40) -> draw = 0.
  - (300,440) -> draw = 0.
- Assert rst_pix for one clock at T+2 with a config pending -> outputs return to INIT values, cfg_ready = 1 after reset, and the pending config is never applied.
